// File: rtl/btn_pkg.sv
// btn_pkg: shared button-scan constants, types and helpers
// Cadence defaults match the display multiplexer so both scan on the same tick.
package btn_pkg;
    localparam int BTN_COUNT          = 4;
    localparam int TICK_DIV_DEF       = 20000;
    localparam int DEBOUNCE_TICKS_DEF = 4;

    typedef logic [1:0] btn_code_t;
    typedef enum logic {EMPTY, FULL} hold_t;

    // Index of the lowest set bit; 0 when none is set.
    function automatic btn_code_t low_idx(input logic [BTN_COUNT-1:0] v);
        low_idx = '0;
        for (int i = BTN_COUNT - 1; i >= 0; i--)
            if (v[i]) low_idx = btn_code_t'(i);
    endfunction
endpackage

// File: rtl/btn_scan_if.sv
// btn_scan_if: button scanner <-> game FSM signal bundle
// btn_in raw buttons, btn_state debounced levels, press_valid/press_code/press_ack
// event handshake, overrun sticky discard flag. master = scanner, slave = FSM side.
interface btn_scan_if;
    import btn_pkg::*;
    logic [BTN_COUNT-1:0] btn_in;
    logic [BTN_COUNT-1:0] btn_state;
    logic                 press_valid;
    btn_code_t            press_code;
    logic                 press_ack;
    logic                 overrun;

    modport master (input btn_in, press_ack, output btn_state, press_valid, press_code, overrun);
    modport slave  (output btn_in, press_ack, input btn_state, press_valid, press_code, overrun);
endinterface

// File: rtl/btn_debounce.sv
// btn_debounce: two-flop synchroniser plus tick-based debounce for one button
// Ports: clk, rst (async, active-high), tick (debounce cadence), btn_raw (async
// input), state (debounced level).
module btn_debounce #(
    parameter int DEBOUNCE_TICKS = btn_pkg::DEBOUNCE_TICKS_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic tick,
    input  logic btn_raw,
    output logic state
);
    localparam int CW = $clog2(DEBOUNCE_TICKS + 1);

    logic [1:0]    sync;
    logic [CW-1:0] cnt;

    // Counter only advances while the synchronised level disagrees with state;
    // any agreement restarts the qualification window.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync  <= '0;
            cnt   <= '0;
            state <= 1'b0;
        end else begin
            sync <= {sync[0], btn_raw};
            if (sync[1] == state)
                cnt <= '0;
            else if (tick && cnt == CW'(DEBOUNCE_TICKS - 1)) begin
                state <= sync[1];
                cnt   <= '0;
            end else if (tick)
                cnt <= cnt + CW'(1);
        end
    end
endmodule

// File: rtl/btn_scan.sv
// btn_scan: debounced push-button scanner delivering one held press event at a time
// Ports: clk, rst (async, active-high), bus (btn_scan_if.master): btn_in in,
// btn_state out, press_valid/press_code out, press_ack in, overrun out.
module btn_scan
    import btn_pkg::*;
#(
    parameter int TICK_DIV       = TICK_DIV_DEF,
    parameter int DEBOUNCE_TICKS = DEBOUNCE_TICKS_DEF
) (
    input logic       clk,
    input logic       rst,
    btn_scan_if.master bus
);
    localparam int PW = $clog2(TICK_DIV + 1);

    logic [PW-1:0]        pre;
    logic                 tick;
    logic [BTN_COUNT-1:0] state, prev, rise;
    logic                 any, multi, ovr;
    hold_t                hs;
    btn_code_t            code;

    assign tick = pre == PW'(TICK_DIV);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) pre <= '0;
        else     pre <= tick ? '0 : pre + PW'(1);
    end

    for (genvar i = 0; i < BTN_COUNT; i++) begin : g_db
        btn_debounce #(.DEBOUNCE_TICKS(DEBOUNCE_TICKS)) u_db (
            .clk    (clk),
            .rst    (rst),
            .tick   (tick),
            .btn_raw(bus.btn_in[i]),
            .state  (state[i])
        );
    end

    assign rise  = state & ~prev;
    assign any   = |rise;
    // More than one bit set: clearing the lowest one leaves something behind.
    assign multi = |(rise & (rise - BTN_COUNT'(1)));

    // An ack frees the slot in the same cycle, so a simultaneous event reloads it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev <= '0;
            hs   <= EMPTY;
            code <= '0;
            ovr  <= 1'b0;
        end else begin
            prev <= state;
            if (multi) ovr <= 1'b1;
            if (hs == EMPTY || bus.press_ack) begin
                hs <= any ? FULL : EMPTY;
                if (any) code <= low_idx(rise);
            end else if (any)
                ovr <= 1'b1;
        end
    end

    assign bus.btn_state   = state;
    assign bus.press_valid = hs == FULL;
    assign bus.press_code  = code;
    assign bus.overrun     = ovr;
endmodule

// File: tb/tb_btn_scan.sv
// tb_btn_scan: directed self-checking bench for btn_scan (TICK_DIV=3, DEBOUNCE_TICKS=2)
module tb_btn_scan;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   passed = 0;
    int   n;
    logic seen_bad;

    btn_scan_if bus();

    btn_scan #(.TICK_DIV(3), .DEBOUNCE_TICKS(2)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.master)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic steps(input int k);
        for (int i = 0; i < k; i++) step();
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic wait_state(input logic [3:0] exp, input int max, output int cnt);
        cnt = 0;
        while (bus.btn_state !== exp && cnt < max) begin
            step();
            cnt++;
        end
    endtask

    task automatic ack_pulse();
        bus.press_ack = 1'b1;
        step();
        bus.press_ack = 1'b0;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_state"}, bus.btn_state, 0);
        chk({tag, "_valid"}, bus.press_valid, 0);
        chk({tag, "_code"}, bus.press_code, 0);
        chk({tag, "_ovr"}, bus.overrun, 0);
    endtask

    initial begin
        bus.btn_in    = '0;
        bus.press_ack = 1'b0;
        steps(3);
        rst = 1'b0;
        steps(20);
        chk_zero("idle");

        // Clean press of button 2
        bus.btn_in = 4'b0100;
        wait_state(4'b0100, 10, n);
        chk("press_state", bus.btn_state, 4'b0100);
        chk("press_not_yet", bus.press_valid, 0);
        step();
        chk("press_valid", bus.press_valid, 1);
        chk("press_code", bus.press_code, 2);
        chk("press_ovr", bus.overrun, 0);
        ack_pulse();
        chk("ack_clears", bus.press_valid, 0);
        bus.btn_in = 4'b0000;
        wait_state(4'b0000, 12, n);
        chk("release_state", bus.btn_state, 0);
        steps(3);
        chk("release_no_event", bus.press_valid, 0);

        // Bounce on button 1: high/low every 3 clocks never spans two ticks
        seen_bad = 1'b0;
        for (int i = 0; i < 40; i++) begin
            bus.btn_in[1] = ((i / 3) % 2) == 0;
            step();
            if (bus.btn_state[1] || bus.press_valid) seen_bad = 1'b1;
        end
        bus.btn_in = 4'b0000;
        for (int i = 0; i < 12; i++) begin
            step();
            if (bus.btn_state[1] || bus.press_valid) seen_bad = 1'b1;
        end
        chk("bounce_rejected", seen_bad, 0);
        chk("bounce_ovr", bus.overrun, 0);

        // Simultaneous press of buttons 0 and 3
        bus.btn_in = 4'b1001;
        wait_state(4'b1001, 10, n);
        chk("simul_state", bus.btn_state, 4'b1001);
        step();
        chk("simul_valid", bus.press_valid, 1);
        chk("simul_code", bus.press_code, 0);
        chk("simul_ovr", bus.overrun, 1);

        // Asynchronous reset mid-run: outputs clear before the next edge
        bus.btn_in = 4'b0000;
        rst = 1'b1;
        #2;
        chk_zero("async_rst");
        steps(2);
        rst = 1'b0;
        steps(20);
        chk_zero("post_rst");

        // Unacked event, then a second press is discarded
        bus.btn_in = 4'b0001;
        wait_state(4'b0001, 10, n);
        chk("unack0_state", bus.btn_state, 4'b0001);
        step();
        chk("unack0_valid", bus.press_valid, 1);
        chk("unack0_code", bus.press_code, 0);
        chk("unack0_ovr", bus.overrun, 0);
        bus.btn_in = 4'b1001;
        wait_state(4'b1001, 10, n);
        chk("unack3_state", bus.btn_state, 4'b1001);
        step();
        chk("unack3_valid", bus.press_valid, 1);
        chk("unack3_code", bus.press_code, 0);
        chk("unack3_ovr", bus.overrun, 1);

        // Press 2 whose load edge coincides with the ack
        bus.btn_in = 4'b1101;
        wait_state(4'b1101, 10, n);
        chk("coinc_state", bus.btn_state, 4'b1101);
        ack_pulse();
        chk("coinc_valid", bus.press_valid, 1);
        chk("coinc_code", bus.press_code, 2);
        chk("coinc_ovr_sticky", bus.overrun, 1);
        ack_pulse();
        chk("coinc_drain", bus.press_valid, 0);
        bus.btn_in = 4'b0000;
        wait_state(4'b0000, 12, n);
        chk("coinc_release", bus.btn_state, 0);
        steps(2);

        // Reset during debounce of button 0
        bus.btn_in = 4'b0001;
        steps(5);
        chk("rstdb_pre", bus.btn_state, 0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        wait_state(4'b0001, 12, n);
        chk("rstdb_state", bus.btn_state, 4'b0001);
        chk("rstdb_min_delay", n >= 7, 1);
        step();
        chk("rstdb_valid", bus.press_valid, 1);
        chk("rstdb_code", bus.press_code, 0);
        ack_pulse();
        seen_bad = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (bus.press_valid) seen_bad = 1'b1;
        end
        chk("rstdb_single_event", seen_bad, 0);
        chk("rstdb_ovr", bus.overrun, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/btn_scan.md
# btn_scan

Input-side counterpart to the seven-segment display multiplexer in the Simon game design. The block samples the four raw player push-buttons and synchronises them. It debounces each button against the same slow tick cadence that the display scan uses. It then turns each clean press into a single event, which is held for the game FSM under a valid/ack handshake. Simultaneous presses and events the FSM never consumed are reported on a sticky overrun flag.

## Interface
Parameters:
- TICK_DIV, 20000: the prescaler counts 0..TICK_DIV, so one debounce tick occurs every TICK_DIV+1 clocks.
- DEBOUNCE_TICKS, 4: number of consecutive ticks for which a button must hold its new level before it is accepted.

Ports:
- clk  in  1  system clock; single clock domain.
- rst  in  1  reset, asynchronous and active-high; clears all state.
- btn_in  in  4  raw buttons, active-high, asynchronous to clk.
- btn_state  out  4  debounced button levels.
- press_valid  out  1  a press event is held and waiting for the FSM.
- press_code  out  2  index of the held press, 0..3; valid only while press_valid=1.
- press_ack  in  1  FSM consumes the held event.
- overrun  out  1  sticky flag, set when a press was discarded; cleared only by rst.

## Operation
- Reset values: btn_state=0, press_valid=0, press_code=0, overrun=0, prescaler=0, synchroniser flops=0, all debounce counters=0.
- Prescaler:
  - Increments every clock.
  - When it equals TICK_DIV, tick=1 for that cycle and the prescaler wraps to 0 on the next edge.
- Synchroniser: each btn_in bit passes through 2 flops to give s[i].
- Per-button debounce:
  - Counter width is clog2(DEBOUNCE_TICKS+1).
  - If s[i]==btn_state[i], the counter clears on that edge, whether or not a tick occurs.
  - Else, on a tick with counter < DEBOUNCE_TICKS-1, the counter increments.
  - Else, on a tick with counter == DEBOUNCE_TICKS-1, btn_state[i] takes the value s[i] and the counter clears.
- Edge detect:
  - rise[i] = btn_state[i] & ~prev[i], where prev is btn_state registered by one cycle.
  - Releases generate no event.
- Event select:
  - If any rise bit is set, the lowest index wins.
  - Any other rise bits set in the same cycle are discarded and set overrun.
- Holding register, two states (EMPTY and FULL, i.e. press_valid 0 and 1):
  - EMPTY, winning event: load press_code and go to FULL.
  - FULL, press_ack=1 and no event: go to EMPTY.
  - FULL, press_ack=1 and a winning event in the same cycle: load the new code and stay FULL.
  - FULL, press_ack=0 and a winning event: discard the event, set overrun, press_code is unchanged.
  - press_ack while EMPTY is ignored.
- Reset mid-operation: every register returns to its reset value immediately (asynchronous). Any partial debounce count or held event is lost.

## Timing
- Raw edge to s[i]: 2 clocks.
- s[i] stable to btn_state[i]: between (DEBOUNCE_TICKS-1)·(TICK_DIV+1)+1 and DEBOUNCE_TICKS·(TICK_DIV+1) clocks, depending on prescaler phase.
- btn_state[i] rising at edge N gives press_valid=1 and press_code=i at edge N+1.
- press_ack sampled high at edge M gives press_valid=0 after edge M, unless a new event is loaded at the same edge.
- overrun rises at the same edge that the discarded event would have been loaded.
- All outputs are registered; there are no combinational paths from any input to any output.

## Structure
- Shared package btn_pkg holds:
  - BTN_COUNT=4
  - typedef btn_code_t (2 bits)
  - default values of TICK_DIV and DEBOUNCE_TICKS, shared with the display multiplexer so both run on the same cadence.
- Sub-module btn_debounce contains the synchroniser, the counter and the btn_state bit for one button.
  - It takes tick as an input.
  - It is instantiated BTN_COUNT times.
  - The prescaler, edge detect, event select and holding register stay at top level.

## Test plan
All scenarios use TICK_DIV=3 (a tick every 4 clocks) and DEBOUNCE_TICKS=2.
- Reset: assert rst mid-run -> all outputs read 0 within the same cycle; after release, btn_in=0 held for 20 clocks -> outputs stay 0.
- Clean press: btn_in=4'b0100 held -> btn_state=4'b0100 within 2+8 clocks, then press_valid=1 with press_code=2 one clock later; press_ack pulse -> press_valid=0 on the next clock; releasing the button -> no new event.
- Bounce rejection: toggle btn_in[1] every 3 clocks for 40 clocks, then hold it at 0 -> btn_state[1] stays 0, press_valid never asserts, overrun=0.
- Simultaneous press: btn_in 0000→1001 in one cycle -> press_code=0, press_valid=1, overrun=1.
- Unacked event: press 0 (no ack), then press 3 -> press_code stays 0 and overrun=1; next, press 2 timed so its load cycle coincides with press_ack -> press_valid stays 1 and press_code=2.
- Reset during debounce: btn_in=4'b0001 with rst pulsed after 5 clocks, button still held -> btn_state[0] rises no earlier than 2+5 clocks after rst release, exactly one event results.
